// File: rtl/counter_pkg.sv
// Shared BCD constants and helpers for the multi-digit up/down counter.
package counter_pkg;

  localparam int unsigned BCD_WIDTH     = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  function automatic logic is_bcd_digit(input logic [BCD_WIDTH-1:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: load (invalid digits load 0), else increment or decrement with 9<->0 rollover.
module bcd_digit
  import counter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 load,
  input  logic [BCD_WIDTH-1:0] load_val,
  output logic [BCD_WIDTH-1:0] digit,
  output logic                 at_max,
  output logic                 at_min
);

  logic [BCD_WIDTH-1:0] digit_d, digit_q;

  always_comb begin
    // NOTE: default first so every path assigns digit_d and no latch is inferred.
    digit_d = digit_q;
    if (load) begin
      digit_d = is_bcd_digit(load_val) ? load_val : '0;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX_DIGIT) ? '0 : digit_q + 4'd1;
    end else if (dec) begin
      digit_d = (digit_q == '0) ? BCD_MAX_DIGIT : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so all flops update from pre-edge values.
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX_DIGIT);
  assign at_min = (digit_q == '0);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with load, enable, terminal count and wrap/saturate boundaries.
module bcd_updown_counter_n
  import counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic                  up_down,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam bit SAT = (SATURATE != 0);

  logic [DIGITS-1:0] at_max, at_min, inc, dec;
  logic [DIGITS:0]   lower_max, lower_min;
  logic              count_up, count_dn, all_max, all_min, hold_sat, any_invalid;
  logic              wrap_d, wrap_q, load_err_d, load_err_q;

  // Digit k may step only when every lower digit sits at its rollover value.
  always_comb begin
    lower_max[0] = 1'b1;
    lower_min[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      lower_max[k+1] = lower_max[k] & at_max[k];
      lower_min[k+1] = lower_min[k] & at_min[k];
    end
  end

  assign all_max  = lower_max[DIGITS];
  assign all_min  = lower_min[DIGITS];
  assign count_up = en & ~load & up_down;
  assign count_dn = en & ~load & ~up_down;
  assign hold_sat = SAT & ((count_up & all_max) | (count_dn & all_min));

  always_comb begin
    inc = '0;
    dec = '0;
    for (int k = 0; k < DIGITS; k++) begin
      inc[k] = count_up & ~hold_sat & lower_max[k];
      dec[k] = count_dn & ~hold_sat & lower_min[k];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[g]),
      .dec      (dec[g]),
      .load     (load),
      .load_val (data_in[4*g +: 4]),
      .digit    (count[4*g +: 4]),
      .at_max   (at_max[g]),
      .at_min   (at_min[g])
    );
  end

  always_comb begin
    any_invalid = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      any_invalid = any_invalid | ~is_bcd_digit(data_in[4*k +: 4]);
    end
    load_err_d = load & any_invalid;
    wrap_d     = ~SAT & ((count_up & all_max) | (count_dn & all_min));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = en & ~load & ((up_down & all_max) | (~up_down & all_min));

endmodule

// File: doc/bcd_updown_counter_n.md
# bcd_updown_counter_n

Parametrised multi-digit BCD up/down counter with synchronous load, count enable, terminal-count output and selectable wrap or saturate mode. It replaces the single-digit decimal up and up/down counters. It sits in timer/display datapaths where several decimal digits must count as one value and cascade to further stages.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; counting happens only when en=1.
- load  in  1  synchronous parallel load; does not require en.
- up_down  in  1  1 = count up, 0 = count down.
- data_in  in  4*DIGITS  BCD load value; digit k is in bits [4k+3:4k].
- count  out  4*DIGITS  registered BCD value; digit 0 is least significant.
- tc  out  1  combinational terminal count (see Operation).
- wrap  out  1  registered one-cycle pulse, high in the cycle after a wrap occurs.
- load_err  out  1  registered one-cycle pulse, high in the cycle after a load that contained an invalid digit.

## Operation

- Priority per cycle: rst, then load, then en. With no rst, no load and en=0, count holds.
- rst: count = 0, wrap = 0, load_err = 0.
- load:
  - Each digit of data_in that is ≤9 loads as given.
  - Each digit >9 loads 0 and does not disturb the other digits.
  - load_err = 1 next cycle if any digit was >9; otherwise 0.
  - wrap = 0.
- Count up (en=1, up_down=1):
  - Digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - Digit k changes only when all lower digits are 9.
- Count down (en=1, up_down=0):
  - Digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - Digit k changes only when all lower digits are 0.
- Boundaries: MAX = all digits 9; MIN = all digits 0.
  - SATURATE=0: MAX up → MIN, and MIN down → MAX. wrap = 1 in the next cycle.
  - SATURATE=1: MAX up holds at MAX, and MIN down holds at MIN. count is unchanged and wrap stays 0.
- tc = en & ~load & ((up_down & count==MAX) | (~up_down & count==MIN)).
  - tc is independent of SATURATE.
  - It is intended as the cascade enable for a following counter stage.
- wrap and load_err are 0 in every cycle not described above.
- Direction changes take effect on the same edge, with no extra pipeline stage.

## Timing

- Latency: count reflects load or count on the first posedge after the inputs are sampled.
- tc: combinational from count, en, load and up_down. Zero-cycle path, no registered delay.
- wrap and load_err: asserted for exactly one cycle, aligned with the count value that results from the wrap or load.
- Reset mid-count: the next posedge forces all outputs to 0 regardless of load/en, including a pending wrap/load_err pulse.
- Simultaneous load and en: the load wins; no count that cycle, and tc = 0.
- Reset values: count = 0, wrap = 0, load_err = 0. tc after reset = en & ~load & ~up_down.

## Structure

- Shared package (counter_pkg):
  - BCD_MAX_DIGIT = 4'd9.
  - BCD_WIDTH = 4.
  - A function that checks whether a digit is valid BCD.
- Sub-module bcd_digit: one digit register with:
  - inputs inc, dec, load, load_val;
  - outputs digit, at_max, at_min.
- The top level generates DIGITS instances and builds the carry/borrow-enable chain from the at_max/at_min AND-prefix.
- The top level also holds the boundary detection, the saturate gating, and the wrap/load_err registers.

## Test plan

All scenarios use DIGITS=2 unless noted.

1. Reset and up-count, SATURATE=0: hold rst 2 cycles, then en=1, up_down=1 for 12 cycles.
   - count goes 00 through 12 with a correct 09→10 carry.
   - tc = 0 throughout; wrap = 0.
2. Up wrap, SATURATE=0: load 98, then en=1, up_down=1.
   - count goes 98 → 99 → 00 → 01.
   - tc = 1 while count = 99.
   - wrap = 1 only in the cycle count = 00.
3. Down wrap and borrow, SATURATE=0: load 10, then up_down=0.
   - count goes 10 → 09 → … → 00 → 99.
   - tc = 1 at 00; wrap = 1 in the cycle count = 99.
4. Saturate, SATURATE=1: load 99 and count up 3 cycles.
   - count stays 99, tc = 1, wrap = 0.
   - Then load 00 and count down: count stays 00.
5. Invalid load and priority:
   - data_in = 8'h5C with load=1 → count = 50, load_err = 1 for one cycle.
   - load and en together with data_in = 8'h37 → count = 37, not 38.
6. Reset mid-operation, DIGITS=4: count up from 9998.
   - Assert rst on the cycle that wraps to 0000.
   - count = 0000 and wrap = 0 next cycle.
   - Counting resumes after rst is released.
